// File: rtl/demux4_deserializer.sv
// 4:1 deserializer: steers WIDTH-bit beats into lanes 0..3 and presents the frame with valid/ready.
// Optional frame parity on par when DEMUX_PARITY_EN is defined; otherwise par is tied low.
module demux4_deserializer #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     d,
    input  logic                 flush,
    output logic [1:0]           s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   q,
    output logic                 par
);

    logic [1:0]         s_reg, s_next;
    logic               out_valid_reg, out_valid_next;
    logic [4*WIDTH-1:0] q_reg, q_next;
    logic [4*WIDTH-1:0] frame;
    logic [WIDTH-1:0]   collect_reg [0:2];
    logic               accept;
    logic               complete;

    // Input stalls while a held frame is not being taken, and during flush.
    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (s_reg == 2'd3);
    assign frame    = {d, collect_reg[2], collect_reg[1], collect_reg[0]};

    always_comb begin
        s_next = s_reg;
        if (flush) begin
            s_next = 2'd0;
        end else if (accept) begin
            s_next = s_reg + 2'd1;
        end
    end

    // A completion on the same edge as a handoff keeps out_valid high (no bubble).
    always_comb begin
        out_valid_next = out_valid_reg;
        if (complete) begin
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_comb begin
        q_next = q_reg;
        if (complete) begin
            q_next = frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg         <= 2'd0;
            out_valid_reg <= 1'b0;
            q_reg         <= '0;
        end else begin
            s_reg         <= s_next;
            out_valid_reg <= out_valid_next;
            q_reg         <= q_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_collect
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    collect_reg[gi] <= '0;
                end else if (accept && (s_reg == 2'(gi))) begin
                    collect_reg[gi] <= d;
                end
            end
        end
    endgenerate

`ifdef DEMUX_PARITY_EN
    logic par_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg <= 1'b0;
        end else if (complete) begin
            par_reg <= ^frame;
        end
    end

    assign par = par_reg;
`else
    assign par = 1'b0;
`endif

    assign s         = s_reg;
    assign out_valid = out_valid_reg;
    assign q         = q_reg;

endmodule
